// File: rtl/riscv_pkg.sv
// Shared RV32I control definitions: opcodes, controller state encoding,
// datapath select encodings and the controller output bundle.
package riscv_pkg;

    localparam int unsigned OPC_W = 7;

    localparam logic [OPC_W-1:0] RTYPE = 7'b0110011;
    localparam logic [OPC_W-1:0] ITYPE = 7'b0010011;
    localparam logic [OPC_W-1:0] LOAD  = 7'b0000011;
    localparam logic [OPC_W-1:0] STORE = 7'b0100011;
    localparam logic [OPC_W-1:0] BEQ   = 7'b1100011;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC_R = 4'd3,
        S_EXEC_I = 4'd4,
        S_ADDR   = 4'd5,
        S_MEM_RD = 4'd6,
        S_MEM_WR = 4'd7,
        S_WB_ALU = 4'd8,
        S_WB_MEM = 4'd9,
        S_BRANCH = 4'd10,
        S_TRAP   = 4'd11
    } ctrl_state_t;

    typedef enum logic [1:0] {
        ASRC_PC    = 2'b00,
        ASRC_OLDPC = 2'b01,
        ASRC_RS1   = 2'b10
    } alu_src_a_t;

    typedef enum logic [1:0] {
        BSRC_RS2  = 2'b00,
        BSRC_IMM  = 2'b01,
        BSRC_FOUR = 2'b10
    } alu_src_b_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    // One cycle's worth of datapath control.
    typedef struct packed {
        logic       imem_req;
        logic       dmem_req;
        logic       pc_wr;
        logic       ir_wr;
        logic       reg_wr;
        logic       mem_wr;
        logic       mem_read;
        logic       mem_to_reg;
        logic       pc_src;
        alu_src_a_t alu_src_a;
        alu_src_b_t alu_src_b;
        alu_op_t    alu_op;
        logic       instr_retired;
        logic       trap;
    } ctrl_out_t;

    localparam ctrl_out_t CTRL_NONE = ctrl_out_t'('0);

    // Wait counter needs at least 4 bits and must be able to hold the limit.
    function automatic int unsigned timer_width(input int unsigned limit);
        if (limit < 32'd16) begin
            return 4;
        end
        return $clog2(limit + 32'd1);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Saturating wait-cycle counter for memory handshakes; flags when the
// number of unanswered request cycles has reached the configured limit.
module mem_wait_timer
    import riscv_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic count_en,
    input  logic clear,
    output logic expired
);

    localparam int unsigned CNT_W = timer_width(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic TIMEOUT_EN = (MEM_TIMEOUT != 0);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_en && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = TIMEOUT_EN && (count_q >= LIMIT);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I sequencer: walks each instruction through fetch, decode,
// execute, memory and writeback, handshaking with instruction/data memory.
module multicycle_control
    import riscv_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       alu_zero,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output logic       imem_req,
    output logic       dmem_req,
    output logic       PCWr,
    output logic       IRWr,
    output logic       RegWr,
    output logic       MemWr,
    output logic       MemRead,
    output logic       MemtoReg,
    output logic       PCSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       instr_retired,
    output logic       trap
);

    ctrl_state_t state_q;
    ctrl_state_t state_d;
    ctrl_out_t   ctrl_c;
    logic        wait_c;
    logic        expired_c;
    logic        clear_c;
    logic        unused_funct3;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus Moore outputs; ready only qualifies completion strobes.
    always_comb begin
        state_d = state_q;
        ctrl_c  = CTRL_NONE;
        wait_c  = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end

            S_FETCH: begin
                ctrl_c.imem_req  = 1'b1;
                ctrl_c.alu_src_a = ASRC_PC;
                ctrl_c.alu_src_b = BSRC_FOUR;
                ctrl_c.alu_op    = ALUOP_ADD;
                ctrl_c.pc_src    = 1'b0;
                if (imem_ready) begin
                    ctrl_c.ir_wr = 1'b1;
                    ctrl_c.pc_wr = 1'b1;
                    state_d      = S_DECODE;
                end else begin
                    wait_c = 1'b1;
                    if (expired_c) begin
                        state_d = S_TRAP;
                    end
                end
            end

            S_DECODE: begin
                ctrl_c.alu_src_a = ASRC_OLDPC;
                ctrl_c.alu_src_b = BSRC_IMM;
                ctrl_c.alu_op    = ALUOP_ADD;
                case (opcode)
                    RTYPE:       state_d = S_EXEC_R;
                    ITYPE:       state_d = S_EXEC_I;
                    LOAD, STORE: state_d = S_ADDR;
                    BEQ:         state_d = S_BRANCH;
                    default:     state_d = S_TRAP;
                endcase
            end

            S_EXEC_R: begin
                ctrl_c.alu_src_a = ASRC_RS1;
                ctrl_c.alu_src_b = BSRC_RS2;
                ctrl_c.alu_op    = ALUOP_FUNCT;
                state_d          = S_WB_ALU;
            end

            S_EXEC_I: begin
                ctrl_c.alu_src_a = ASRC_RS1;
                ctrl_c.alu_src_b = BSRC_IMM;
                ctrl_c.alu_op    = ALUOP_FUNCT;
                state_d          = S_WB_ALU;
            end

            S_ADDR: begin
                ctrl_c.alu_src_a = ASRC_RS1;
                ctrl_c.alu_src_b = BSRC_IMM;
                ctrl_c.alu_op    = ALUOP_ADD;
                state_d          = (opcode == LOAD) ? S_MEM_RD : S_MEM_WR;
            end

            S_MEM_RD: begin
                ctrl_c.dmem_req = 1'b1;
                ctrl_c.mem_read = 1'b1;
                if (dmem_ready) begin
                    state_d = S_WB_MEM;
                end else begin
                    wait_c = 1'b1;
                    if (expired_c) begin
                        state_d = S_TRAP;
                    end
                end
            end

            S_MEM_WR: begin
                ctrl_c.dmem_req = 1'b1;
                ctrl_c.mem_wr   = 1'b1;
                if (dmem_ready) begin
                    ctrl_c.instr_retired = 1'b1;
                    state_d              = S_FETCH;
                end else begin
                    wait_c = 1'b1;
                    if (expired_c) begin
                        state_d = S_TRAP;
                    end
                end
            end

            S_WB_ALU: begin
                ctrl_c.reg_wr        = 1'b1;
                ctrl_c.mem_to_reg    = 1'b0;
                ctrl_c.instr_retired = 1'b1;
                state_d              = S_FETCH;
            end

            S_WB_MEM: begin
                ctrl_c.reg_wr        = 1'b1;
                ctrl_c.mem_to_reg    = 1'b1;
                ctrl_c.instr_retired = 1'b1;
                state_d              = S_FETCH;
            end

            // funct3[0] turns BEQ into BNE by inverting the zero test.
            S_BRANCH: begin
                ctrl_c.alu_src_a     = ASRC_RS1;
                ctrl_c.alu_src_b     = BSRC_RS2;
                ctrl_c.alu_op        = ALUOP_SUB;
                ctrl_c.pc_src        = 1'b1;
                ctrl_c.pc_wr         = alu_zero ^ funct3[0];
                ctrl_c.instr_retired = 1'b1;
                state_d              = S_FETCH;
            end

            S_TRAP: begin
                ctrl_c.trap = 1'b1;
            end

            default: begin
                state_d = S_TRAP;
            end
        endcase
    end

    assign clear_c = (state_d != state_q);

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_mem_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .count_en(wait_c),
        .clear   (clear_c),
        .expired (expired_c)
    );

    assign imem_req      = ctrl_c.imem_req;
    assign dmem_req      = ctrl_c.dmem_req;
    assign PCWr          = ctrl_c.pc_wr;
    assign IRWr          = ctrl_c.ir_wr;
    assign RegWr         = ctrl_c.reg_wr;
    assign MemWr         = ctrl_c.mem_wr;
    assign MemRead       = ctrl_c.mem_read;
    assign MemtoReg      = ctrl_c.mem_to_reg;
    assign PCSrc         = ctrl_c.pc_src;
    assign ALUSrcA       = ctrl_c.alu_src_a;
    assign ALUSrcB       = ctrl_c.alu_src_b;
    assign ALUOp         = ctrl_c.alu_op;
    assign instr_retired = ctrl_c.instr_retired;
    assign trap          = ctrl_c.trap;

    // Only the BEQ/BNE bit of funct3 matters to the sequencer.
    assign unused_funct3 = ^funct3[2:1];

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-cycle vectors built from instruction-level
// rules (directed cases plus a random instruction stream), applied in one loop.
module tb_multicycle_control;

    localparam int unsigned TMO = 15;

    typedef struct packed {
        logic       imem_req;
        logic       dmem_req;
        logic       pcwr;
        logic       irwr;
        logic       regwr;
        logic       memwr;
        logic       memread;
        logic       memtoreg;
        logic       pcsrc;
        logic [1:0] asel;
        logic [1:0] bsel;
        logic [1:0] aop;
        logic       ret;
        logic       trap;
    } out_t;

    typedef struct {
        string      name;
        logic       rst;
        logic       chk;
        logic [6:0] opc;
        logic [2:0] f3;
        logic       zero;
        logic       iready;
        logic       dready;
        out_t       exp;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       alu_zero;
    logic       imem_ready;
    logic       dmem_ready;
    logic       imem_req;
    logic       dmem_req;
    logic       PCWr;
    logic       IRWr;
    logic       RegWr;
    logic       MemWr;
    logic       MemRead;
    logic       MemtoReg;
    logic       PCSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic       instr_retired;
    logic       trap;

    multicycle_control #(
        .MEM_TIMEOUT(TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .funct3       (funct3),
        .alu_zero     (alu_zero),
        .imem_ready   (imem_ready),
        .dmem_ready   (dmem_ready),
        .imem_req     (imem_req),
        .dmem_req     (dmem_req),
        .PCWr         (PCWr),
        .IRWr         (IRWr),
        .RegWr        (RegWr),
        .MemWr        (MemWr),
        .MemRead      (MemRead),
        .MemtoReg     (MemtoReg),
        .PCSrc        (PCSrc),
        .ALUSrcA      (ALUSrcA),
        .ALUSrcB      (ALUSrcB),
        .ALUOp        (ALUOp),
        .instr_retired(instr_retired),
        .trap         (trap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    vec_t       vq[$];
    logic [6:0] cur_opc;
    logic [2:0] cur_f3;
    logic       cur_zero;
    int         total;
    int         bad;

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic is_legal(input logic [6:0] o);
        return o inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011};
    endfunction

    function automatic logic [6:0] illegal_opc();
        logic [6:0] o;
        do begin
            o = 7'($urandom);
        end while (is_legal(o));
        return o;
    endfunction

    // Junk cycles drive random opcode/funct3: IR contents are not valid yet.
    task automatic push(input string nm, input out_t e, input logic ir, input logic dr, input logic junk);
        vec_t v;
        v.name   = nm;
        v.rst    = 1'b0;
        v.chk    = 1'b1;
        v.opc    = junk ? 7'($urandom) : cur_opc;
        v.f3     = junk ? 3'($urandom) : cur_f3;
        v.zero   = cur_zero;
        v.iready = ir;
        v.dready = dr;
        v.exp    = e;
        vq.push_back(v);
    endtask

    // n cycles of rst: the first shows the pre-reset state, the rest must be idle.
    task automatic do_reset(input int n);
        vec_t v;
        for (int k = 0; k < n; k++) begin
            v.name   = "reset";
            v.rst    = 1'b1;
            v.chk    = (k != 0);
            v.opc    = 7'($urandom);
            v.f3     = 3'($urandom);
            v.zero   = rb();
            v.iready = rb();
            v.dready = rb();
            v.exp    = '0;
            vq.push_back(v);
        end
        push("idle", '0, rb(), rb(), 1'b1);
    endtask

    task automatic do_fetch(input int fw);
        out_t e;
        e = '0;
        e.imem_req = 1'b1;
        e.bsel     = 2'b10;
        for (int k = 0; k < fw; k++) push("fetch_wait", e, 1'b0, rb(), 1'b1);
        e.irwr = 1'b1;
        e.pcwr = 1'b1;
        push("fetch_done", e, 1'b1, rb(), 1'b1);
    endtask

    task automatic do_decode();
        out_t e;
        e = '0;
        e.asel = 2'b01;
        e.bsel = 2'b01;
        push("decode", e, rb(), rb(), 1'b0);
    endtask

    task automatic do_addr();
        out_t e;
        e = '0;
        e.asel = 2'b10;
        e.bsel = 2'b01;
        push("addr", e, rb(), rb(), 1'b0);
    endtask

    task automatic do_trap(input int n);
        out_t e;
        e = '0;
        e.trap = 1'b1;
        for (int k = 0; k < n; k++) push("trap_hold", e, rb(), rb(), 1'b1);
    endtask

    // kind: 0 R, 1 I, 2 load, 3 store, 4 branch, 5 random illegal, 6 opcode 7F
    task automatic do_instr(input int kind, input int fw, input int mw, input logic [2:0] f3, input logic z);
        out_t e;
        case (kind)
            0:       cur_opc = 7'b0110011;
            1:       cur_opc = 7'b0010011;
            2:       cur_opc = 7'b0000011;
            3:       cur_opc = 7'b0100011;
            4:       cur_opc = 7'b1100011;
            5:       cur_opc = illegal_opc();
            default: cur_opc = 7'b1111111;
        endcase
        cur_f3   = f3;
        cur_zero = z;
        do_fetch(fw);
        do_decode();
        case (kind)
            0, 1: begin
                e = '0;
                e.asel = 2'b10;
                e.bsel = (kind == 1) ? 2'b01 : 2'b00;
                e.aop  = 2'b10;
                push("exec", e, rb(), rb(), 1'b0);
                e = '0;
                e.regwr = 1'b1;
                e.ret   = 1'b1;
                push("wb_alu", e, rb(), rb(), 1'b0);
            end
            2, 3: begin
                do_addr();
                e = '0;
                e.dmem_req = 1'b1;
                e.memread  = (kind == 2);
                e.memwr    = (kind == 3);
                for (int k = 0; k < mw; k++) push("mem_wait", e, rb(), 1'b0, 1'b0);
                e.ret = (kind == 3);
                push("mem_done", e, rb(), 1'b1, 1'b0);
                if (kind == 2) begin
                    e = '0;
                    e.regwr    = 1'b1;
                    e.memtoreg = 1'b1;
                    e.ret      = 1'b1;
                    push("wb_mem", e, rb(), rb(), 1'b0);
                end
            end
            4: begin
                e = '0;
                e.asel  = 2'b10;
                e.aop   = 2'b01;
                e.pcsrc = 1'b1;
                e.pcwr  = z ^ f3[0];
                e.ret   = 1'b1;
                push("branch", e, rb(), rb(), 1'b0);
            end
            default: ;
        endcase
    endtask

    task automatic build();
        out_t e;
        do_reset(2);
        // Zero-wait R-type stream, I-type, loads/stores with waits, branches.
        for (int k = 0; k < 3; k++) do_instr(0, 0, 0, 3'($urandom), rb());
        do_instr(1, 0, 0, 3'($urandom), rb());
        do_instr(2, 0, 3, 3'($urandom), rb());
        do_instr(2, 0, 0, 3'($urandom), rb());
        do_instr(3, 0, 0, 3'($urandom), rb());
        do_instr(4, 0, 0, 3'b000, 1'b1);
        do_instr(4, 0, 0, 3'b001, 1'b1);
        do_instr(4, 0, 0, 3'b000, 1'b0);
        do_instr(4, 0, 0, 3'b001, 1'b0);
        do_instr(0, 2, 0, 3'($urandom), rb());
        // Timeout boundary: ready on the last allowed wait cycles.
        do_instr(3, 0, 14, 3'($urandom), rb());
        do_instr(3, 0, 15, 3'($urandom), rb());
        do_instr(2, 15, 15, 3'($urandom), rb());
        // Store that never completes.
        cur_opc = 7'b0100011;
        do_fetch(0);
        do_decode();
        do_addr();
        e = '0;
        e.dmem_req = 1'b1;
        e.memwr    = 1'b1;
        for (int k = 0; k < int'(TMO) + 1; k++) push("wr_hang", e, rb(), 1'b0, 1'b0);
        do_trap(4);
        do_reset(1);
        // Fetch that never completes.
        e = '0;
        e.imem_req = 1'b1;
        e.bsel     = 2'b10;
        for (int k = 0; k < int'(TMO) + 1; k++) push("fetch_hang", e, 1'b0, rb(), 1'b1);
        do_trap(3);
        do_reset(2);
        // Illegal opcode holds in trap until reset.
        do_instr(6, 0, 0, 3'($urandom), rb());
        do_trap(20);
        do_reset(1);
        // Reset in the middle of a load access.
        cur_opc = 7'b0000011;
        do_fetch(0);
        do_decode();
        do_addr();
        e = '0;
        e.dmem_req = 1'b1;
        e.memread  = 1'b1;
        push("rd_wait", e, rb(), 1'b0, 1'b0);
        push("rd_wait", e, rb(), 1'b0, 1'b0);
        do_reset(1);
        // Random instruction stream.
        for (int n = 0; n < 60; n++) begin
            int r;
            int kind;
            int fw;
            int mw;
            r    = $urandom_range(19, 0);
            kind = (r < 19) ? (r % 5) : 5;
            fw   = ($urandom_range(3, 0) == 0) ? $urandom_range(15, 0) : 0;
            mw   = ($urandom_range(1, 0) == 0) ? $urandom_range(15, 0) : 0;
            do_instr(kind, fw, mw, 3'($urandom), rb());
            if (kind == 5) begin
                do_trap(3);
                do_reset($urandom_range(2, 1));
            end
        end
    endtask

    initial begin
        out_t got;
        out_t trap_only;
        total      = 0;
        bad        = 0;
        rst        = 1'b1;
        opcode     = '0;
        funct3     = '0;
        alu_zero   = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        cur_opc    = '0;
        cur_f3     = '0;
        cur_zero   = 1'b0;
        trap_only      = '0;
        trap_only.trap = 1'b1;
        build();
        for (int i = 0; i < vq.size(); i++) begin
            @(posedge clk);
            #1;
            rst        = vq[i].rst;
            opcode     = vq[i].opc;
            funct3     = vq[i].f3;
            alu_zero   = vq[i].zero;
            imem_ready = vq[i].iready;
            dmem_ready = vq[i].dready;
            #3;
            if (vq[i].chk) begin
                got = {imem_req, dmem_req, PCWr, IRWr, RegWr, MemWr, MemRead, MemtoReg,
                       PCSrc, ALUSrcA, ALUSrcB, ALUOp, instr_retired, trap};
                total++;
                if (vq[i].rst) begin
                    if (got !== out_t'('0)) begin
                        bad++;
                        $display("FAIL reset vec=%0d got=%h want=0", i, got);
                    end
                end else if (vq[i].name == "trap_hold") begin
                    if (got !== trap_only) begin
                        bad++;
                        $display("FAIL trap vec=%0d got=%h want=%h", i, got, trap_only);
                    end
                end else if (got !== vq[i].exp) begin
                    bad++;
                    $display("FAIL %s vec=%0d got=%h want=%h", vq[i].name, i, got, vq[i].exp);
                end
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
